filter_sync_tx: RTL and testbench

- Source-domain launcher for the filter synchronizer. It takes bus updates through a valid/ready handshake and drives them onto the crossing bus straight from flops.
- Each launched value is held stable for at least HOLD_CYCLES source clocks, so the destination-side filter always sees a settled bus.
- Sits in clock domain A, directly in front of the filter_sync bus_in.

---
 rtl/filter_sync_pkg.sv | 17 +
 rtl/filter_sync_hold_cnt.sv | 29 ++
 rtl/filter_sync_tx.sv | 103 ++++++++++
 tb/tb_filter_sync_tx.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/filter_sync_pkg.sv
// rtl/filter_sync_pkg.sv - shared types and sizing helpers for the filter synchronizer launcher
package filter_sync_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_e;

    localparam int DEF_WIDTH       = 4;
    localparam int DEF_HOLD_CYCLES = 4;

    // A hold of 1 or 2 still needs a one-bit counter so the reload value has somewhere to live.
    function automatic int cnt_width(input int hold);
        return (hold <= 2) ? 1 : $clog2(hold);
    endfunction

endpackage

// File: rtl/filter_sync_hold_cnt.sv
// rtl/filter_sync_hold_cnt.sv - loadable down-counter that times the minimum bus hold
module filter_sync_hold_cnt #(
    parameter int CW = 2
) (
    input  logic          clk_a,
    input  logic          rstb_a,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    output logic          zero
);

    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic [CW-1:0] cnt;

    // Saturates at zero so an idle launcher leaves the counter parked.
    always_ff @(posedge clk_a or negedge rstb_a) begin
        if (!rstb_a) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - CNT_ONE;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/filter_sync_tx.sv
// rtl/filter_sync_tx.sv - source-domain launcher holding each bus value for HOLD_CYCLES clocks
module filter_sync_tx
    import filter_sync_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int HOLD_CYCLES = DEF_HOLD_CYCLES
) (
    input  logic             clk_a,
    input  logic             rstb_a,
    input  logic [WIDTH-1:0] data_in,
    input  logic             valid_in,
    output logic             ready_out,
    output logic [WIDTH-1:0] bus_out,
    output logic             busy,
    output logic             launched
);

    localparam int            CW     = cnt_width(HOLD_CYCLES);
    localparam logic [CW-1:0] RELOAD = CW'(HOLD_CYCLES - 1);

    state_e           state, state_nx;
    logic [WIDTH-1:0] bus_q, bus_nx;
    logic [WIDTH-1:0] pend_q, pend_nx;
    logic             pend_v_q, pend_v_nx;
    logic             launched_q;
    logic             launch_nx;
    logic             accept;
    logic             cnt_zero;

    assign ready_out = !pend_v_q;
    assign accept    = valid_in && !pend_v_q;

    filter_sync_hold_cnt #(
        .CW (CW)
    ) u_hold_cnt (
        .clk_a    (clk_a),
        .rstb_a   (rstb_a),
        .load     (launch_nx),
        .load_val (RELOAD),
        .zero     (cnt_zero)
    );

    always_comb begin
        state_nx  = state;
        bus_nx    = bus_q;
        pend_nx   = pend_q;
        pend_v_nx = pend_v_q;
        launch_nx = 1'b0;
        case (state)
            IDLE: begin
                if (accept && (data_in != bus_q)) begin
                    bus_nx    = data_in;
                    launch_nx = 1'b1;
                    state_nx  = HOLD;
                end
            end
            HOLD: begin
                if (!cnt_zero) begin
                    if (accept) begin
                        pend_nx   = data_in;
                        pend_v_nx = 1'b1;
                    end
                end else if (pend_v_q) begin
                    pend_v_nx = 1'b0;
                    if (pend_q != bus_q) begin
                        bus_nx    = pend_q;
                        launch_nx = 1'b1;
                    end else begin
                        state_nx = IDLE;
                    end
                end else if (accept && (data_in != bus_q)) begin
                    // Hold just expired and nothing is queued: launch straight from the input.
                    bus_nx    = data_in;
                    launch_nx = 1'b1;
                end else begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_a or negedge rstb_a) begin
        if (!rstb_a) begin
            state      <= IDLE;
            bus_q      <= '0;
            pend_q     <= '0;
            pend_v_q   <= 1'b0;
            launched_q <= 1'b0;
        end else begin
            state      <= state_nx;
            bus_q      <= bus_nx;
            pend_q     <= pend_nx;
            pend_v_q   <= pend_v_nx;
            launched_q <= launch_nx;
        end
    end

    assign bus_out  = bus_q;
    assign busy     = (state == HOLD);
    assign launched = launched_q;

endmodule

// File: tb/tb_filter_sync_tx.sv
// tb/tb_filter_sync_tx.sv - self-checking bench for filter_sync_tx at hold lengths 4 and 1
module tb_filter_sync_tx;

    typedef struct {
        logic [3:0] bus;
        logic [3:0] pend;
        bit         pend_v;
        bit         in_hold;
        bit         launched;
        bit         acc;
        int         age;
    } model_t;

    logic       clk_a  = 1'b0;
    logic       rstb_a = 1'b0;
    logic [3:0] data4  = '0;
    logic       valid4 = 1'b0;
    logic [3:0] data1  = '0;
    logic       valid1 = 1'b0;
    logic       ready4, busy4, launched4;
    logic       ready1, busy1, launched1;
    logic [3:0] bus4, bus1;

    int     n_checks = 0;
    int     n_fail   = 0;
    int     edge_n   = 0;
    int     last4    = 0;
    bit     have4    = 0;
    logic [3:0] prev4 = '0;
    int     pulses4  = 0;
    model_t m4, m1;

    always #5 clk_a = ~clk_a;

    filter_sync_tx #(.WIDTH(4), .HOLD_CYCLES(4)) dut4 (
        .clk_a(clk_a), .rstb_a(rstb_a), .data_in(data4), .valid_in(valid4),
        .ready_out(ready4), .bus_out(bus4), .busy(busy4), .launched(launched4)
    );

    filter_sync_tx #(.WIDTH(4), .HOLD_CYCLES(1)) dut1 (
        .clk_a(clk_a), .rstb_a(rstb_a), .data_in(data1), .valid_in(valid1),
        .ready_out(ready1), .bus_out(bus1), .busy(busy1), .launched(launched1)
    );

    function automatic model_t model_reset();
        model_t m;
        m.bus = '0; m.pend = '0; m.pend_v = 0; m.in_hold = 0;
        m.launched = 0; m.acc = 0; m.age = 0;
        return m;
    endfunction

    // One clock edge of the launcher rules: a value may only replace the bus once
    // hold-1 further edges have passed since the previous launch.
    function automatic model_t model_step(model_t m, int hold, bit v, logic [3:0] d);
        model_t     n;
        bit         acc;
        bit         go;
        logic [3:0] nv;
        n = m;
        acc = v && !m.pend_v;
        go = 0;
        nv = m.bus;
        n.launched = 0;
        n.acc = acc;
        if (!m.in_hold) begin
            if (acc && d != m.bus) begin go = 1; nv = d; end
        end else if (m.age < hold - 1) begin
            if (acc) begin n.pend = d; n.pend_v = 1; end
        end else begin
            if (m.pend_v) begin
                n.pend_v = 0;
                if (m.pend != m.bus) begin go = 1; nv = m.pend; end
            end else if (acc && d != m.bus) begin
                go = 1; nv = d;
            end
            if (!go) n.in_hold = 0;
        end
        if (go) begin
            n.bus = nv; n.age = 0; n.in_hold = 1; n.launched = 1;
        end else begin
            n.age = m.age + 1;
        end
        return n;
    endfunction

    task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk4("bus4", bus4, m4.bus);
        chk1("ready4", ready4, !m4.pend_v);
        chk1("busy4", busy4, m4.in_hold);
        chk1("launched4", launched4, m4.launched);
        chk4("bus1", bus1, m1.bus);
        chk1("ready1", ready1, !m1.pend_v);
        chk1("busy1", busy1, m1.in_hold);
        chk1("launched1", launched1, m1.launched);
        if (launched4 === 1'b1) pulses4++;
        if (bus4 !== prev4) begin
            if (have4) begin
                n_checks++;
                assert (edge_n - last4 >= 4) else begin
                    n_fail++;
                    $error("FAIL gap4 observed=%0d required>=4", edge_n - last4);
                end
            end
            have4 = 1;
            last4 = edge_n;
            prev4 = bus4;
        end
    endtask

    task automatic tick(input bit va, input logic [3:0] da, input bit vb, input logic [3:0] db);
        valid4 = va; data4 = da; valid1 = vb; data1 = db;
        @(posedge clk_a);
        m4 = model_step(m4, 4, va, da);
        m1 = model_step(m1, 1, vb, db);
        edge_n++;
        #1;
        check_all();
    endtask

    initial begin
        logic [3:0] b2b_q[$];
        int         p0;
        int         guard;

        m4 = model_reset();
        m1 = model_reset();

        // Reset held for 15ns, released on a clock edge
        #12;
        chk4("rst_bus4", bus4, 4'b0000);
        chk1("rst_ready4", ready4, 1'b1);
        chk1("rst_busy4", busy4, 1'b0);
        chk1("rst_launched4", launched4, 1'b0);
        @(posedge clk_a);
        rstb_a = 1'b1;
        #1;
        check_all();

        // Same value as the reset bus: accepted, no launch
        tick(1, 4'b0000, 0, 4'b0000);
        chk1("same_busy", busy4, 1'b0);
        chk1("same_launched", launched4, 1'b0);

        // Single launch: busy for exactly four cycles
        tick(1, 4'b1010, 0, 4'b0000);
        chk4("single_bus", bus4, 4'b1010);
        chk1("single_launched", launched4, 1'b1);
        for (int i = 0; i < 5; i++) tick(0, 4'b0000, 0, 4'b0000);
        chk1("single_idle", busy4, 1'b0);

        // Bypass: new value presented exactly on the counter-zero edge
        tick(1, 4'b0011, 0, 4'b0000);
        for (int i = 0; i < 3; i++) tick(0, 4'b0000, 0, 4'b0000);
        tick(1, 4'b0110, 0, 4'b0000);
        chk4("bypass_bus", bus4, 4'b0110);
        chk1("bypass_busy", busy4, 1'b1);
        chk1("bypass_launched", launched4, 1'b1);
        for (int i = 0; i < 4; i++) tick(0, 4'b0000, 0, 4'b0000);

        // Back-to-back traffic: three launches, four edges apart
        p0 = pulses4;
        b2b_q = '{4'b1010, 4'b0101, 4'b1111};
        guard = 0;
        while (b2b_q.size() != 0 && guard < 40) begin
            tick(1, b2b_q[0], 0, 4'b0000);
            if (m4.acc) void'(b2b_q.pop_front());
            guard++;
        end
        chk4("b2b_drained", 4'(b2b_q.size()), 4'd0);
        for (int i = 0; i < 10; i++) tick(0, 4'b0000, 0, 4'b0000);
        chk4("b2b_pulses", 4'(pulses4 - p0), 4'd3);
        chk4("b2b_final", bus4, 4'b1111);

        // Reset in the middle of a hold with a value pending
        tick(1, 4'b1100, 0, 4'b0000);
        tick(0, 4'b0000, 0, 4'b0000);
        tick(1, 4'b0111, 0, 4'b0000);
        chk1("midrst_pending", ready4, 1'b0);
        #3;
        rstb_a = 1'b0;
        #1;
        m4 = model_reset();
        m1 = model_reset();
        chk4("midrst_bus4", bus4, 4'b0000);
        chk1("midrst_busy4", busy4, 1'b0);
        chk1("midrst_ready4", ready4, 1'b1);
        chk1("midrst_launched4", launched4, 1'b0);
        chk4("midrst_bus1", bus1, 4'b0000);
        have4 = 0;
        prev4 = '0;
        @(negedge clk_a);
        rstb_a = 1'b1;

        // Hold of one: a new value every edge
        tick(0, 4'b0000, 1, 4'b0001);
        chk4("h1_bus_a", bus1, 4'b0001);
        chk1("h1_rdy_a", ready1, 1'b1);
        tick(0, 4'b0000, 1, 4'b0010);
        chk4("h1_bus_b", bus1, 4'b0010);
        chk1("h1_rdy_b", ready1, 1'b1);
        tick(0, 4'b0000, 1, 4'b0011);
        chk4("h1_bus_c", bus1, 4'b0011);
        chk1("h1_rdy_c", ready1, 1'b1);
        chk1("h1_launched_c", launched1, 1'b1);

        // Randomised traffic on both instances
        for (int i = 0; i < 600; i++) begin
            tick(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
